regfile_dump_ctrl: RTL and testbench

Hardware counterpart of the simulation register dump. It reads the CPU debug port by driving reg_sel and sampling reg_data, and serialises a snapshot of PC, instruction and all GPRs into a byte stream. The stream uses a valid/ready handshake toward a UART/host-link transmitter. It sits in sccomp next to U_SCPU and shares the existing reg_sel/reg_data debug port.

---
 rtl/regfile_dump_ctrl_pkg.sv | 22 ++
 rtl/regfile_dump_ctrl_if.sv | 10 +
 rtl/regfile_dump_ctrl_byte_tx.sv | 57 +++++
 rtl/regfile_dump_ctrl.sv | 170 +++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared types and frame geometry for the register-dump streamer.
// Header is sync plus PC and INSTR; each register adds 4 bytes; checksum closes the frame.
package dbg_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEL,
    ST_WAIT,
    ST_SEND,
    ST_CHK,
    ST_FIN
  } state_e;

  localparam int         FRAME_HDR_BYTES = 9;
  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;

  function automatic int frame_len(input int num_regs);
    return FRAME_HDR_BYTES + 4 * num_regs + 1;
  endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Byte stream toward the UART/host-link transmitter.
// A byte moves when tx_valid && tx_ready; the master holds tx_valid and tx_data until then.
interface regfile_dump_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump_ctrl_byte_tx.sv
// Output byte register with valid/ready hold and a running XOR checksum.
// Load takes effect next cycle; a held byte stays put until the sink accepts it.
module dump_byte_tx (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       load_i,
  input  logic [7:0]                 byte_i,
  input  logic                       chk_en_i,
  input  logic                       chk_clr_i,
  regfile_dump_ctrl_if.master        tx,
  output logic                       accept_o,
  output logic                       free_o,
  output logic [7:0]                 chk_o
);

  logic       vld_q, vld_d;
  logic [7:0] dat_q, dat_d;
  logic [7:0] chk_q, chk_d;

  assign accept_o = vld_q && tx.tx_ready;
  // The slot can take a new byte in the same cycle the current one leaves.
  assign free_o   = !vld_q || accept_o;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    chk_d = chk_q;
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = byte_i;
    end else if (accept_o) begin
      vld_d = 1'b0;
    end
    if (chk_clr_i) begin
      chk_d = 8'h00;
    end else if (load_i && chk_en_i) begin
      chk_d = chk_q ^ byte_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      dat_q <= 8'h00;
      chk_q <= 8'h00;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      chk_q <= chk_d;
    end
  end

  assign tx.tx_valid = vld_q;
  assign tx.tx_data  = dat_q;
  assign chk_o       = chk_q;

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Snapshots PC, INSTR and GPRs via the debug port into a checksummed byte frame.
// Up to one byte per cycle inside header/word runs; stalls on tx_ready with data held.
module regfile_dump_ctrl
  import dbg_dump_pkg::*;
#(
  parameter int         NUM_REGS  = 32,
  parameter int         READ_LAT  = 1,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic [31:0]         pc_in,
  input  logic [31:0]         instr_in,
  output logic [4:0]          reg_sel,
  input  logic [31:0]         reg_data,
  regfile_dump_ctrl_if.master tx,
  output logic                busy,
  output logic                done
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  reg_sel_q, reg_sel_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] word_q, word_d;

  logic        ld, chk_en, chk_clr;
  logic [7:0]  ld_byte;
  logic        tx_acc, tx_free;
  logic [7:0]  chk_val;
  logic [71:0] hdr_sh;

  dump_byte_tx u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (ld),
    .byte_i    (ld_byte),
    .chk_en_i  (chk_en),
    .chk_clr_i (chk_clr),
    .tx        (tx),
    .accept_o  (tx_acc),
    .free_o    (tx_free),
    .chk_o     (chk_val)
  );

  // cnt_q counts bytes loaded in the current run; a run ends when its last byte is accepted.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    idx_d     = idx_q;
    reg_sel_d = reg_sel_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    word_d    = word_q;
    ld        = 1'b0;
    ld_byte   = 8'h00;
    chk_en    = 1'b0;
    chk_clr   = 1'b0;
    hdr_sh    = {SYNC_BYTE, pc_q, instr_q} << {cnt_q, 3'b000};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = pc_in;
          instr_d = instr_in;
          chk_clr = 1'b1;
          idx_d   = 5'd0;
          cnt_d   = 4'd0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (tx_free && cnt_q < 4'(FRAME_HDR_BYTES)) begin
          ld      = 1'b1;
          ld_byte = hdr_sh[71:64];
          chk_en  = (cnt_q != 4'd0);
          cnt_d   = cnt_q + 4'd1;
        end else if (cnt_q == 4'(FRAME_HDR_BYTES) && tx_acc) begin
          cnt_d     = 4'd0;
          reg_sel_d = idx_q;
          state_d   = ST_SEL;
        end
      end
      ST_SEL: begin
        if (READ_LAT == 0) begin
          word_d  = (idx_q == 5'd0) ? 32'h0 : reg_data;
          state_d = ST_SEND;
        end else begin
          wait_d  = 2'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_q == 2'(READ_LAT - 1)) begin
          // r0 is architecturally zero whatever the debug port returns.
          word_d  = (idx_q == 5'd0) ? 32'h0 : reg_data;
          state_d = ST_SEND;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_SEND: begin
        if (tx_free && cnt_q < 4'd4) begin
          ld      = 1'b1;
          ld_byte = word_q[31:24];
          chk_en  = 1'b1;
          word_d  = {word_q[23:0], 8'h00};
          cnt_d   = cnt_q + 4'd1;
        end else if (cnt_q == 4'd4 && tx_acc) begin
          cnt_d = 4'd0;
          if (idx_q == 5'(NUM_REGS - 1)) begin
            state_d = ST_CHK;
          end else begin
            idx_d     = idx_q + 5'd1;
            reg_sel_d = idx_q + 5'd1;
            state_d   = ST_SEL;
          end
        end
      end
      ST_CHK: begin
        if (tx_free && cnt_q == 4'd0) begin
          ld      = 1'b1;
          ld_byte = chk_val;
          cnt_d   = 4'd1;
        end else if (cnt_q == 4'd1 && tx_acc) begin
          cnt_d   = 4'd0;
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      pc_q      <= 32'h0;
      instr_q   <= 32'h0;
      idx_q     <= 5'd0;
      reg_sel_q <= 5'd0;
      cnt_q     <= 4'd0;
      wait_q    <= 2'd0;
      word_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      idx_q     <= idx_d;
      reg_sel_q <= reg_sel_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      word_q    <= word_d;
    end
  end

  assign reg_sel = reg_sel_q;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done    = (state_q == ST_FIN);

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Two instances (read latency 1 and 2) driven in lockstep and checked against a frame-level model.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, start;
  logic [31:0] pc_in, instr_in;
  logic [4:0]  reg_sel1, reg_sel2;
  logic [31:0] reg_data1, reg_data2, pipe2;
  logic        busy1, busy2, done1, done2;
  int          ready_mode;

  regfile_dump_ctrl_if if1();
  regfile_dump_ctrl_if if2();

  regfile_dump_ctrl #(.NUM_REGS(32), .READ_LAT(1), .SYNC_BYTE(8'hA5)) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start), .pc_in(pc_in), .instr_in(instr_in),
    .reg_sel(reg_sel1), .reg_data(reg_data1), .tx(if1), .busy(busy1), .done(done1)
  );

  regfile_dump_ctrl #(.NUM_REGS(32), .READ_LAT(2), .SYNC_BYTE(8'hA5)) u_dut2 (
    .clk(clk), .rstn(rstn), .start(start), .pc_in(pc_in), .instr_in(instr_in),
    .reg_sel(reg_sel2), .reg_data(reg_data2), .tx(if2), .busy(busy2), .done(done2)
  );

  // Register file behind the debug port: latency 1 for dut1, latency 2 for dut2.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    reg_data1 <= rf[reg_sel1];
    pipe2     <= rf[reg_sel2];
    reg_data2 <= pipe2;
  end

  logic [7:0] exp_mem [2][256];
  int         exp_len [2];
  int         ptr     [2];
  int         frames  [2];
  bit         active  [2];
  bit         pend    [2];
  bit         stall   [2];
  logic [7:0] stall_dat [2];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] prev_sel;
  int         hold;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected frame straight from the frame definition: sync, PC, INSTR, registers, XOR.
  task automatic build_frame(input int k, input logic [31:0] pc, input logic [31:0] ins);
    int          p;
    logic [7:0]  x, bt;
    logic [31:0] w;
    p = 0;
    x = 8'h00;
    exp_mem[k][p] = 8'hA5;
    p++;
    for (int wi = 0; wi < 34; wi++) begin
      if (wi == 0) w = pc;
      else if (wi == 1) w = ins;
      else if (wi == 2) w = 32'h0;
      else w = rf[wi - 2];
      for (int b = 3; b >= 0; b--) begin
        bt = 8'(w >> (8 * b));
        exp_mem[k][p] = bt;
        x = x ^ bt;
        p++;
      end
    end
    exp_mem[k][p] = x;
    p++;
    exp_len[k] = p;
    ptr[k] = 0;
  endtask

  task automatic model_step(input int k, input logic vld, input logic rdy, input logic [7:0] dat,
                            input logic bsy, input logic dn);
    bit was_pend;
    if (!rstn) begin
      check(!vld && !bsy && !dn, "reset_outputs", {29'h0, vld, bsy, dn}, 32'h0);
      active[k] = 1'b0;
      pend[k]   = 1'b0;
      stall[k]  = 1'b0;
      ptr[k]    = 0;
      return;
    end
    was_pend = pend[k];
    check(bsy == (active[k] && !was_pend), "busy", {31'h0, bsy}, {31'h0, active[k] && !was_pend});
    check(dn == was_pend, "done", {31'h0, dn}, {31'h0, was_pend});
    if (stall[k])
      check(vld && dat == stall_dat[k], "hold_stable", {23'h0, vld, dat}, {24'h1, stall_dat[k]});
    if (vld)
      check(active[k] && !was_pend && ptr[k] < exp_len[k], "valid_in_frame", 32'(ptr[k]), 32'(exp_len[k]));
    if (vld && rdy) begin
      if (ptr[k] < exp_len[k]) begin
        check(dat == exp_mem[k][ptr[k]], "byte", {24'h0, dat}, {24'h0, exp_mem[k][ptr[k]]});
        ptr[k]++;
        if (ptr[k] == exp_len[k]) pend[k] = 1'b1;
      end
      stall[k] = 1'b0;
    end else begin
      stall[k]     = vld;
      stall_dat[k] = dat;
    end
    if (was_pend) begin
      active[k] = 1'b0;
      pend[k]   = 1'b0;
      frames[k]++;
    end else if (!active[k] && start) begin
      active[k] = 1'b1;
      build_frame(k, pc_in, instr_in);
    end
  endtask

  // Single compare process: both streams plus reg_sel dwell of the slow-port instance.
  always @(negedge clk) begin
    model_step(0, if1.tx_valid, if1.tx_ready, if1.tx_data, busy1, done1);
    model_step(1, if2.tx_valid, if2.tx_ready, if2.tx_data, busy2, done2);
    if (!rstn) begin
      hold     = 0;
      prev_sel = reg_sel2;
    end else if (reg_sel2 != prev_sel) begin
      check(hold >= 3, "reg_sel_dwell", 32'(hold), 32'd3);
      hold     = 1;
      prev_sel = reg_sel2;
    end else begin
      hold++;
    end
  end

  function automatic logic gen_ready();
    if (ready_mode == 0) return 1'b1;
    if (ready_mode == 1) return ($urandom_range(2) == 0);
    return 1'($urandom_range(1));
  endfunction

  initial begin
    if1.tx_ready = 1'b0;
    if2.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if1.tx_ready = gen_ready();
      if2.tx_ready = gen_ready();
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk);
      if (!active[0] && !active[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, name, {31'h0, ok}, 32'h1);
  endtask

  task automatic wait_ptr(input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (ptr[0] >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check(ok, name, 32'(ptr[0]), 32'(n));
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    pc_in      = 32'h0;
    instr_in   = 32'h0;
    ready_mode = 0;
    prev_sel   = 5'd0;
    hold       = 0;
    for (int k = 0; k < 2; k++) begin
      exp_len[k] = 0; ptr[k] = 0; frames[k] = 0;
      active[k] = 1'b0; pend[k] = 1'b0; stall[k] = 1'b0; stall_dat[k] = 8'h00;
    end
    rf[0] = 32'h0;
    for (int k = 1; k < 32; k++) rf[k] = 32'h1000_0000 + 32'(k);

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check(reg_sel1 == 5'd0 && reg_sel2 == 5'd0, "reset_reg_sel", {27'h0, reg_sel1}, 32'h0);

    // Directed frame, sink always ready; pin the model to hand-derived bytes.
    pc_in    = 32'h0000_0048;
    instr_in = 32'h2008_0005;
    pulse_start();
    check(exp_len[0] == 138, "model_len", 32'(exp_len[0]), 32'd138);
    check(exp_mem[0][0] == 8'hA5 && exp_mem[0][4] == 8'h48, "model_hdr",
          {exp_mem[0][0], exp_mem[0][4]}, 32'hA548);
    check(exp_mem[0][5] == 8'h20 && exp_mem[0][8] == 8'h05, "model_instr",
          {exp_mem[0][5], exp_mem[0][8]}, 32'h2005);
    check(exp_mem[0][16] == 8'h01 && exp_mem[0][133] == 8'h10 && exp_mem[0][136] == 8'h1F, "model_regs",
          {exp_mem[0][16], exp_mem[0][133], exp_mem[0][136]}, 32'h01101F);
    check(exp_mem[0][137] == 8'h75, "model_chk", {24'h0, exp_mem[0][137]}, 32'h75);
    wait_idle("frame1_timeout");

    // Same frame with a 1-in-3 ready sink.
    ready_mode = 1;
    pulse_start();
    wait_idle("frame2_timeout");

    // r0 forced non-zero on the port, random contents, 50% ready.
    rf[0] = 32'hDEAD_BEEF;
    for (int k = 1; k < 32; k++) rf[k] = $urandom;
    pc_in      = $urandom;
    instr_in   = $urandom;
    ready_mode = 2;
    pulse_start();
    check({exp_mem[0][9], exp_mem[0][10], exp_mem[0][11], exp_mem[0][12]} == 32'h0, "model_r0",
          {exp_mem[0][9], exp_mem[0][10], exp_mem[0][11], exp_mem[0][12]}, 32'h0);
    wait_idle("frame3_timeout");

    // Start again mid-frame and move PC: neither may disturb the frame in flight.
    ready_mode = 1;
    pulse_start();
    wait_ptr(50, "byte50_timeout");
    pulse_start();
    pc_in    = $urandom;
    instr_in = $urandom;
    wait_idle("frame4_timeout");
    repeat (20) @(posedge clk);
    check(frames[0] == 4 && frames[1] == 4 && !busy1 && !busy2, "no_second_frame",
          32'(frames[0]), 32'd4);

    // Abort with reset part-way through, then a clean frame.
    pulse_start();
    wait_ptr(70, "byte70_timeout");
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check(!if1.tx_valid && !busy1 && !if2.tx_valid && !busy2, "abort_immediate",
          {28'h0, if1.tx_valid, busy1, if2.tx_valid, busy2}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    check(frames[0] == 4 && frames[1] == 4, "abort_no_done", 32'(frames[1]), 32'd4);
    pulse_start();
    wait_idle("frame5_timeout");
    repeat (5) @(posedge clk);
    check(frames[0] == 5 && frames[1] == 5, "frame_count", 32'(frames[0]), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
